pipe_slice: RTL and testbench
=============================

Name: pipe_slice

Overview:
- Parametrised elastic valid/ready register slice that replaces the fixed single-entry per-stage buses between pipeline stages (fetch/decode/execute/memory/writeback) of the core.
- Carries an opaque DATA_W-bit stage payload through DEPTH entries of buffering.
- Adds a synchronous flush for branch/trap redirect, and a registered ready so no combinational path runs from m_ready to s_ready.

Parameters:
- DATA_W, 32, payload width in bits (1..512).
- DEPTH, 2, number of buffer entries (1..16, need not be a power of two).
- RESET_VAL, 0, value loaded into every storage entry at reset (DATA_W bits).

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  discard all buffered entries and any input offered this cycle
- s_valid  in  1  upstream payload valid
- s_ready  out  1  slice can accept; depends only on registered state and rst/flush
- s_data  in  DATA_W  upstream payload
- m_valid  out  1  payload available downstream
- m_ready  in  1  downstream accepts
- m_data  out  DATA_W  head-of-buffer payload
- count  out  $clog2(DEPTH+1)  number of occupied entries

Behaviour:
- Clocking: one clock. Reset is synchronous, active-high (clk, rst).
- Reset:
  - count=0, write pointer=0, read pointer=0, all entries=RESET_VAL.
  - m_valid=0, m_data=RESET_VAL.
  - s_ready=0 while rst=1.
- Push: when s_valid & s_ready, s_data is written at the write pointer and count is incremented.
- Pop: when m_valid & m_ready, the read pointer advances and count is decremented.
- s_ready = !rst & !flush & (count < DEPTH). m_ready is never used to compute it. A full slice refuses input even if a pop happens in the same cycle.
- m_valid = (count != 0). m_data = entry at the read pointer. Both are purely registered-state driven.
- Latency:
  - A payload accepted in cycle N is visible on m_valid/m_data in cycle N+1. There is no same-cycle bypass.
  - Throughput is 1 beat/cycle for DEPTH>=2. DEPTH=1 gives at most 1 beat per 2 cycles.
- Simultaneous push and pop (count not 0 and not DEPTH): count is unchanged and both pointers advance.
- Pointer wrap: a pointer equal to DEPTH-1 advances to 0. Wrap must be correct for DEPTH that is not a power of two (e.g. 3).
- Stability: while m_valid & !m_ready, m_data and m_valid hold unchanged.
- Protocol assumption: upstream holds s_data/s_valid until accepted. The slice does not check this.
- Flush:
  - In the flush cycle, s_ready=0, so no push occurs. A pop that handshakes in that cycle still counts as delivered downstream.
  - Next cycle: count=0, pointers=0, m_valid=0.
  - Storage contents are not cleared, so m_data shows the stale entry 0.
- Flush and rst together: rst dominates (full reset).
- Empty: m_valid=0, m_data shows the entry at the read pointer (stale), and m_ready is ignored.
- Full: s_ready=0 and s_valid is ignored. Data already buffered is never overwritten.

Optional Feature:
- Macro: PIPE_SLICE_PERF_EN.
- When defined, adds the following outputs:
  - perf_beats (32-bit): +1 per pop handshake.
  - perf_stall (32-bit): +1 per cycle with m_valid & !m_ready.
  - perf_full (32-bit): +1 per cycle with s_valid & !s_ready & !flush.
- Counter rules:
  - All three wrap at 2^32.
  - Cleared by rst only; flush does not clear them.
  - perf_beats counts a pop occurring during a flush cycle.
- When not defined, these ports and their registers do not exist. Core behaviour is identical either way.

Test Plan:
- Reset, then streaming (DEPTH=2, DATA_W=32): hold rst for 2 cycles -> m_valid=0, count=0, s_ready=0 during rst and 1 the cycle after. Then push 0x11, 0x22, 0x33 on consecutive cycles with m_ready=1 -> m_data 0x11, 0x22, 0x33 in cycles 2, 3, 4, continuous m_valid.
- Backpressure: m_ready=0, push 0xA0, 0xA1, 0xA2 -> first two accepted, count=2, s_ready=0 with 0xA2 held. Then m_ready=1 -> 0xA0 pops. 0xA2 is accepted only in the cycle after count drops, and output order is 0xA0, 0xA1, 0xA2.
- Wrap (DEPTH=3): push and pop 10 beats 0..9 with random m_ready gaps -> output sequence is exactly 0..9 and count never exceeds 3.
- Flush: count=2 (0x5, 0x6); assert flush together with s_valid=1, s_data=0x7 -> s_ready=0 in that cycle, next cycle m_valid=0 and count=0, and 0x7 is never emitted. A subsequent push of 0x8 appears alone.
- DEPTH=1: continuous s_valid and m_ready=1 -> accepts alternate cycles, 1 beat per 2 cycles, values in order.
- PIPE_SLICE_PERF_EN: 4 pops, 3 stall cycles, 2 refused-input cycles, then a flush -> perf_beats=4, perf_stall=3, perf_full=2, unchanged after the flush, all 0 after rst.

Source files
------------

// File: rtl/pipe_slice.sv
// rtl/pipe_slice.sv - elastic valid/ready register slice with flush and registered s_ready
//
// Purpose: carries an opaque DATA_W-bit payload between pipeline stages through
// DEPTH entries of buffering. s_ready and m_valid/m_data are functions of registered
// state (plus rst/flush for s_ready), so no combinational path runs m_ready -> s_ready.
//
// Ports:
//   clk      in   clock, all state on rising edge
//   rst      in   synchronous active-high reset
//   flush    in   drop all buffered entries and any input offered this cycle
//   s_valid  in   upstream payload valid
//   s_ready  out  slice can accept (count < DEPTH, not in rst/flush)
//   s_data   in   upstream payload
//   m_valid  out  payload available downstream (count != 0)
//   m_ready  in   downstream accepts
//   m_data   out  head-of-buffer payload (stale entry when empty)
//   count    out  number of occupied entries
//
// Optional (macro PIPE_SLICE_PERF_EN): perf_beats, perf_stall, perf_full 32-bit
// wrapping event counters, cleared by rst only.

module pipe_slice #(
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 2,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [DATA_W-1:0]          s_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [DATA_W-1:0]          m_data,
  output logic [$clog2(DEPTH+1)-1:0] count
`ifdef PIPE_SLICE_PERF_EN
  ,
  output logic [31:0]                perf_beats,
  output logic [31:0]                perf_stall,
  output logic [31:0]                perf_full
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  // A single-entry slice still needs a 1-bit pointer to have a legal vector.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]     wr_q, wr_d;
  logic [PW-1:0]     rd_q, rd_d;
  logic [CW-1:0]     count_q, count_d;
  logic              push, pop;

  // Explicit wrap at DEPTH-1 keeps non-power-of-two depths correct.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // A full slice refuses input even when a pop happens this cycle; that is what
  // keeps m_ready out of the s_ready cone.
  assign s_ready = !rst && !flush && (count_q < FULL_CNT);
  assign m_valid = (count_q != '0);
  assign m_data  = mem_q[rd_q];
  assign count   = count_q;

  assign push = s_valid && s_ready;
  assign pop  = m_valid && m_ready;

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    if (flush) begin
      // A pop in the flush cycle was already delivered downstream; everything
      // left behind is dropped. Storage is left as-is.
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (push) wr_d = ptr_inc(wr_q);
      if (pop)  rd_d = ptr_inc(rd_q);
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= RESET_VAL;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      if (push) mem_q[wr_q] <= s_data;
    end
  end

`ifdef PIPE_SLICE_PERF_EN
  logic [31:0] perf_beats_q, perf_stall_q, perf_full_q;

  // Flush does not clear these; a pop during flush still counts as a beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_beats_q <= '0;
      perf_stall_q <= '0;
      perf_full_q  <= '0;
    end else begin
      if (pop)                           perf_beats_q <= perf_beats_q + 32'd1;
      if (m_valid && !m_ready)           perf_stall_q <= perf_stall_q + 32'd1;
      if (s_valid && !s_ready && !flush) perf_full_q  <= perf_full_q + 32'd1;
    end
  end

  assign perf_beats = perf_beats_q;
  assign perf_stall = perf_stall_q;
  assign perf_full  = perf_full_q;
`endif

endmodule

// File: tb/tb_pipe_slice.sv
// tb/tb_pipe_slice.sv - directed vector bench for pipe_slice (DEPTH 2, 3 and 1)
module tb_pipe_slice;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic        rst;
  // instance a: DEPTH=2, DATA_W=32, non-zero RESET_VAL
  logic        flush_a, sv_a, mr_a, sr_a, mv_a;
  logic [31:0] sd_a, md_a;
  logic [1:0]  cnt_a;
  // instance b: DEPTH=3, DATA_W=8
  logic        flush_b, sv_b, mr_b, sr_b, mv_b;
  logic [7:0]  sd_b, md_b;
  logic [1:0]  cnt_b;
  // instance c: DEPTH=1, DATA_W=8
  logic        flush_c, sv_c, mr_c, sr_c, mv_c;
  logic [7:0]  sd_c, md_c;
  logic [0:0]  cnt_c;

`ifdef PIPE_SLICE_PERF_EN
  logic [31:0] pb_a, ps_a, pf_a, pb_b, ps_b, pf_b, pb_c, ps_c, pf_c;
`endif

  localparam logic [31:0] RV = 32'hDEAD_BEEF;

  pipe_slice #(.DATA_W(32), .DEPTH(2), .RESET_VAL(RV)) u_a (
    .clk(clk), .rst(rst), .flush(flush_a), .s_valid(sv_a), .s_ready(sr_a),
    .s_data(sd_a), .m_valid(mv_a), .m_ready(mr_a), .m_data(md_a), .count(cnt_a)
`ifdef PIPE_SLICE_PERF_EN
    , .perf_beats(pb_a), .perf_stall(ps_a), .perf_full(pf_a)
`endif
  );

  pipe_slice #(.DATA_W(8), .DEPTH(3), .RESET_VAL(8'h00)) u_b (
    .clk(clk), .rst(rst), .flush(flush_b), .s_valid(sv_b), .s_ready(sr_b),
    .s_data(sd_b), .m_valid(mv_b), .m_ready(mr_b), .m_data(md_b), .count(cnt_b)
`ifdef PIPE_SLICE_PERF_EN
    , .perf_beats(pb_b), .perf_stall(ps_b), .perf_full(pf_b)
`endif
  );

  pipe_slice #(.DATA_W(8), .DEPTH(1), .RESET_VAL(8'h00)) u_c (
    .clk(clk), .rst(rst), .flush(flush_c), .s_valid(sv_c), .s_ready(sr_c),
    .s_data(sd_c), .m_valid(mv_c), .m_ready(mr_c), .m_data(md_c), .count(cnt_c)
`ifdef PIPE_SLICE_PERF_EN
    , .perf_beats(pb_c), .perf_stall(ps_c), .perf_full(pf_c)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        r, f, sv;
    logic [31:0] sd;
    logic        mr;
    logic        e_sr, e_mv;
    logic [31:0] e_md;
    logic [1:0]  e_cnt;
  } vec_t;

  vec_t tbl[26];

  task automatic drive_a(input logic r, input logic f, input logic sv,
                         input logic [31:0] sd, input logic mr);
    @(negedge clk);
    rst = r; flush_a = f; sv_a = sv; sd_a = sd; mr_a = mr;
    #1;
  endtask

  initial begin
    int nin, nout, mcount;
    logic psh, pp;

    //            r  f  sv  sd            mr   sr mv  md            cnt
    tbl[0]  = '{1, 0, 0, 32'h0,        0,   0, 0, RV,           2'd0};
    tbl[1]  = '{0, 0, 1, 32'h11,       1,   1, 0, RV,           2'd0};
    tbl[2]  = '{0, 0, 1, 32'h22,       1,   1, 1, 32'h11,       2'd1};
    tbl[3]  = '{0, 0, 1, 32'h33,       1,   1, 1, 32'h22,       2'd1};
    tbl[4]  = '{0, 0, 0, 32'h0,        1,   1, 1, 32'h33,       2'd1};
    tbl[5]  = '{0, 0, 0, 32'h0,        0,   1, 0, 32'h22,       2'd0};
    tbl[6]  = '{0, 0, 1, 32'hA0,       0,   1, 0, 32'h22,       2'd0};
    tbl[7]  = '{0, 0, 1, 32'hA1,       0,   1, 1, 32'hA0,       2'd1};
    tbl[8]  = '{0, 0, 1, 32'hA2,       0,   0, 1, 32'hA0,       2'd2};
    tbl[9]  = '{0, 0, 1, 32'hA2,       1,   0, 1, 32'hA0,       2'd2};
    tbl[10] = '{0, 0, 1, 32'hA2,       1,   1, 1, 32'hA1,       2'd1};
    tbl[11] = '{0, 0, 0, 32'h0,        1,   1, 1, 32'hA2,       2'd1};
    tbl[12] = '{0, 0, 0, 32'h0,        0,   1, 0, 32'hA1,       2'd0};
    tbl[13] = '{0, 0, 1, 32'h05,       0,   1, 0, 32'hA1,       2'd0};
    tbl[14] = '{0, 0, 1, 32'h06,       0,   1, 1, 32'h05,       2'd1};
    tbl[15] = '{0, 1, 1, 32'h07,       0,   0, 1, 32'h05,       2'd2};
    tbl[16] = '{0, 0, 0, 32'h0,        0,   1, 0, 32'h05,       2'd0};
    tbl[17] = '{0, 0, 1, 32'h08,       0,   1, 0, 32'h05,       2'd0};
    tbl[18] = '{0, 0, 0, 32'h0,        1,   1, 1, 32'h08,       2'd1};
    tbl[19] = '{0, 0, 0, 32'h0,        0,   1, 0, 32'h06,       2'd0};
    tbl[20] = '{1, 1, 1, 32'h0,        0,   0, 0, 32'h06,       2'd0};
    tbl[21] = '{0, 0, 0, 32'h0,        0,   1, 0, RV,           2'd0};
    tbl[22] = '{0, 0, 1, 32'hC1,       0,   1, 0, RV,           2'd0};
    tbl[23] = '{0, 0, 1, 32'hC2,       0,   1, 1, 32'hC1,       2'd1};
    tbl[24] = '{0, 1, 0, 32'h0,        1,   0, 1, 32'hC1,       2'd2};
    tbl[25] = '{0, 0, 0, 32'h0,        0,   1, 0, 32'hC1,       2'd0};

    rst = 1'b1;
    flush_a = 0; sv_a = 0; sd_a = '0; mr_a = 0;
    flush_b = 0; sv_b = 0; sd_b = '0; mr_b = 0;
    flush_c = 0; sv_c = 0; sd_c = '0; mr_c = 0;

    @(negedge clk); #1;
    chk("reset cycle1 s_ready", {63'b0, sr_a}, 64'd0);

    for (int i = 0; i < 26; i++) begin
      drive_a(tbl[i].r, tbl[i].f, tbl[i].sv, tbl[i].sd, tbl[i].mr);
      chk($sformatf("vec%0d s_ready", i), {63'b0, sr_a}, {63'b0, tbl[i].e_sr});
      chk($sformatf("vec%0d m_valid", i), {63'b0, mv_a}, {63'b0, tbl[i].e_mv});
      chk($sformatf("vec%0d m_data", i),  {32'b0, md_a}, {32'b0, tbl[i].e_md});
      chk($sformatf("vec%0d count", i),   {62'b0, cnt_a}, {62'b0, tbl[i].e_cnt});
    end

`ifdef PIPE_SLICE_PERF_EN
    drive_a(1, 0, 0, 32'h0, 0);
    drive_a(0, 0, 1, 32'h1, 0);
    chk("perf after rst beats", {32'b0, pb_a}, 64'd0);
    chk("perf after rst stall", {32'b0, ps_a}, 64'd0);
    chk("perf after rst full",  {32'b0, pf_a}, 64'd0);
    drive_a(0, 0, 1, 32'h2, 0);
    drive_a(0, 0, 1, 32'h3, 0);
    drive_a(0, 0, 1, 32'h3, 0);
    drive_a(0, 0, 0, 32'h0, 1);
    drive_a(0, 0, 0, 32'h0, 1);
    drive_a(0, 0, 1, 32'h4, 1);
    drive_a(0, 0, 1, 32'h5, 1);
    drive_a(0, 1, 0, 32'h0, 1);
    drive_a(0, 0, 0, 32'h0, 0);
    chk("perf beats", {32'b0, pb_a}, 64'd4);
    chk("perf stall", {32'b0, ps_a}, 64'd3);
    chk("perf full",  {32'b0, pf_a}, 64'd2);
    drive_a(0, 0, 0, 32'h0, 0);
    chk("perf beats post flush", {32'b0, pb_a}, 64'd4);
    chk("perf stall post flush", {32'b0, ps_a}, 64'd3);
    chk("perf full post flush",  {32'b0, pf_a}, 64'd2);
    drive_a(1, 0, 0, 32'h0, 0);
    drive_a(0, 0, 0, 32'h0, 0);
    chk("perf beats cleared", {32'b0, pb_a}, 64'd0);
    chk("perf stall cleared", {32'b0, ps_a}, 64'd0);
    chk("perf full cleared",  {32'b0, pf_a}, 64'd0);
`endif

    // DEPTH=3 wrap with random downstream gaps; instance b is empty after the table's reset.
    nin = 0; nout = 0; mcount = 0;
    for (int cyc = 0; cyc < 300 && nout < 10; cyc++) begin
      @(negedge clk);
      rst = 0;
      sv_b = (nin < 10);
      sd_b = 8'(nin);
      mr_b = 1'($urandom_range(0, 1));
      #1;
      chk("wrap count", {62'b0, cnt_b}, 64'(mcount));
      chk("wrap s_ready", {63'b0, sr_b}, {63'b0, (mcount < 3)});
      psh = sv_b && sr_b;
      pp  = mv_b && mr_b;
      if (pp) begin
        chk("wrap m_data", {56'b0, md_b}, 64'(nout));
        nout++;
      end
      if (psh) nin++;
      mcount = mcount + int'(psh) - int'(pp);
    end
    chk("wrap beats delivered", 64'(nout), 64'd10);
    sv_b = 0; mr_b = 0;

    // DEPTH=1: continuous offer and drain accepts on alternate cycles.
    nin = 0; nout = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      sv_c = 1; sd_c = 8'(nin + 8'h40); mr_c = 1;
      #1;
      chk($sformatf("d1 s_ready k%0d", k), {63'b0, sr_c}, {63'b0, (k % 2 == 0)});
      chk($sformatf("d1 m_valid k%0d", k), {63'b0, mv_c}, {63'b0, (k % 2 == 1)});
      if (mv_c && mr_c) begin
        chk("d1 m_data", {56'b0, md_c}, 64'(nout + 8'h40));
        nout++;
      end
      if (sv_c && sr_c) nin++;
    end
    chk("d1 beats in",  64'(nin),  64'd5);
    chk("d1 beats out", 64'(nout), 64'd5);
    sv_c = 0; mr_c = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
